// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, RGB565 field layout and the colour
// expansion helper used by the scanout pipeline.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Timing flags carried down the delay pipeline; sync bits mean "in pulse".
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic origin;
    } scan_flags_t;

    // Replicate the top bits of each field into the low bits so full scale maps to 8'hFF.
    function automatic rgb888_t expand_rgb565(input logic [15:0] d);
        rgb888_t c;
        c.r = {d[R_MSB:R_LSB], d[R_MSB -: 3]};
        c.g = {d[G_MSB:G_LSB], d[G_MSB -: 2]};
        c.b = {d[B_MSB:B_LSB], d[B_MSB -: 3]};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with the raw (undelayed) display
// enable, sync-pulse and frame-origin flags decoded from them.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int HW       = $clog2(H_TOT),
    parameter int VW       = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output scan_flags_t   flags,
    output logic          frame_last
);

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt_reg == HW'(H_TOT - 1));
    assign v_last = (v_cnt_reg == VW'(V_TOT - 1));

    // Dropping en parks the raster at the origin so a re-enable starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (!en) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_last) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        flags        = '0;
        flags.de     = (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));
        flags.hs     = (h_cnt_reg >= HW'(H_ACTIVE + H_FP)) &&
                       (h_cnt_reg <  HW'(H_ACTIVE + H_FP + H_SYNC));
        flags.vs     = (v_cnt_reg >= VW'(V_ACTIVE + V_FP)) &&
                       (v_cnt_reg <  VW'(V_ACTIVE + V_FP + V_SYNC));
        flags.origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end

    assign h_cnt      = h_cnt_reg;
    assign v_cnt      = v_cnt_reg;
    assign frame_last = h_last && v_last;

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster scanout: walks a linear framebuffer address in step with the VGA
// timing, delays the timing flags to match the ROM, and expands RGB565.
module framebuffer_scanout
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter int   RD_LATENCY  = 1,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] fb_addr,
    input  logic [15:0] fb_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int PIPE  = RD_LATENCY + 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    scan_flags_t   raw_flags;
    logic          frame_last;
    logic          last_active;
    logic [31:0]   pix_addr_reg;
    logic          data_de;
    rgb888_t       rgb_reg;

    scan_flags_t [PIPE-1:0] pipe_reg;
    scan_flags_t [PIPE-1:0] pipe_next;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .flags      (raw_flags),
        .frame_last (frame_last)
    );

    // The final visible pixel does not advance the address, so it parks on the
    // last valid index through vertical blanking instead of running one past.
    assign last_active = (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_addr_reg <= '0;
        end else if (!en || frame_last) begin
            pix_addr_reg <= '0;
        end else if (raw_flags.de && !last_active) begin
            pix_addr_reg <= pix_addr_reg + 32'd1;
        end
    end

    assign fb_addr = pix_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_next[gi] = raw_flags;
            end else begin : g_tail
                assign pipe_next[gi] = pipe_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_reg <= '0;
        end else if (!en) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    // Enable flag for the pixel whose ROM word is on fb_data this cycle.
    generate
        if (RD_LATENCY == 0) begin : g_de_comb
            assign data_de = raw_flags.de;
        end else begin : g_de_piped
            assign data_de = pipe_reg[RD_LATENCY-1].de;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_reg <= '0;
        end else if (!en || !data_de) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= expand_rgb565(fb_data);
        end
    end

    assign de          = pipe_reg[PIPE-1].de;
    assign frame_start = pipe_reg[PIPE-1].origin;
    assign hsync       = pipe_reg[PIPE-1].hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync       = pipe_reg[PIPE-1].vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign r           = rgb_reg.r;
    assign g           = rgb_reg.g;
    assign b           = rgb_reg.b;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench: a default 640x480 instance and a shrunken-timing
// instance share one ROM image and are compared against a raster model.
module tb_framebuffer_scanout;

    localparam int NPIX = 307200;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [31:0] addr;
    } obs_t;

    localparam obs_t RST_EXP = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 32'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [31:0] fb_addr_a, fb_addr_b;
    logic [15:0] fb_data_a = 16'h0, fb_data_b = 16'h0;
    logic        hsync_a, vsync_a, de_a, frame_start_a;
    logic        hsync_b, vsync_b, de_b, frame_start_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [15:0] mem [NPIX];

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc    = 0;

    // Index 0: default 640x480 timing, index 1: shrunken raster (25 x 11).
    int t_ha [2] = '{640, 16};
    int t_hf [2] = '{16, 2};
    int t_hs [2] = '{96, 4};
    int t_hb [2] = '{48, 3};
    int t_va [2] = '{480, 6};
    int t_vf [2] = '{10, 1};
    int t_vs [2] = '{2, 2};
    int t_vb [2] = '{33, 2};

    framebuffer_scanout u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fb_addr     (fb_addr_a),
        .fb_data     (fb_data_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .de          (de_a),
        .r           (r_a),
        .g           (g_a),
        .b           (b_a),
        .frame_start (frame_start_a)
    );

    framebuffer_scanout #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fb_addr     (fb_addr_b),
        .fb_data     (fb_data_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .de          (de_b),
        .r           (r_b),
        .g           (g_b),
        .b           (b_b),
        .frame_start (frame_start_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_read(input logic [31:0] a);
        if (a < 32'(NPIX)) return mem[int'(a)];
        return 16'h0;
    endfunction

    // One-cycle-latency ROM for each instance.
    always @(posedge clk) begin
        fb_data_a <= rom_read(fb_addr_a);
        fb_data_b <= rom_read(fb_addr_b);
    end

    function automatic obs_t observe(input int d);
        if (d == 0) return {de_a, hsync_a, vsync_a, frame_start_a, r_a, g_a, b_a, fb_addr_a};
        return {de_b, hsync_b, vsync_b, frame_start_b, r_b, g_b, b_b, fb_addr_b};
    endfunction

    // Expected outputs n edges after en was raised at the raster origin.
    function automatic obs_t model(input int d, input int n);
        obs_t        e;
        int          ht, vt, f, p, x, y, cnt, last;
        logic [15:0] pix;
        ht   = t_ha[d] + t_hf[d] + t_hs[d] + t_hb[d];
        vt   = t_va[d] + t_vf[d] + t_vs[d] + t_vb[d];
        f    = ht * vt;
        last = t_va[d] * t_ha[d] - 1;
        p    = n % f;
        x    = p % ht;
        y    = p / ht;
        if (y < t_va[d]) cnt = y * t_ha[d] + ((x < t_ha[d]) ? x : t_ha[d]);
        else             cnt = t_va[d] * t_ha[d];
        if (cnt > last) cnt = last;
        e      = RST_EXP;
        e.addr = 32'(cnt);
        if (n >= 2) begin
            p    = (n - 2) % f;
            x    = p % ht;
            y    = p / ht;
            e.de = (x < t_ha[d]) && (y < t_va[d]);
            e.hs = !((x >= t_ha[d] + t_hf[d]) && (x < t_ha[d] + t_hf[d] + t_hs[d]));
            e.vs = !((y >= t_va[d] + t_vf[d]) && (y < t_va[d] + t_vf[d] + t_vs[d]));
            e.fs = (p == 0);
            if (e.de) begin
                pix = mem[y * t_ha[d] + x];
                e.r = 8'((int'(pix[15:11]) << 3) | (int'(pix[15:11]) >> 2));
                e.g = 8'((int'(pix[10:5])  << 2) | (int'(pix[10:5])  >> 4));
                e.b = 8'((int'(pix[4:0])   << 3) | (int'(pix[4:0])   >> 2));
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            n_checks++;
            if (o !== RST_EXP) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got %h want %h", d, o, RST_EXP);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                n_checks++;
                if (o !== RST_EXP) begin
                    n_errors++;
                    $display("FAIL idle_en0 dut%0d cyc%0d: got %h want %h", d, i, o, RST_EXP);
                end
            end
        end
        $display("test_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_first_pixels();
        obs_t       o;
        logic [23:0] want_rgb [4];
        want_rgb = '{24'hFF0000, 24'h848284, 24'h00FF00, 24'h0000FF};
        en    = 1'b1;
        n_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                n_checks++;
                if (o.fs !== (n_cyc == 2)) begin
                    n_errors++;
                    $display("FAIL frame_start dut%0d n=%0d: got %b want %b", d, n_cyc, o.fs, n_cyc == 2);
                end
                n_checks++;
                if (o.addr !== 32'(n_cyc)) begin
                    n_errors++;
                    $display("FAIL start_addr dut%0d n=%0d: got %0d want %0d", d, n_cyc, o.addr, n_cyc);
                end
                if (n_cyc >= 2) begin
                    n_checks++;
                    if ({o.de, o.r, o.g, o.b} !== {1'b1, want_rgb[n_cyc-2]}) begin
                        n_errors++;
                        $display("FAIL first_rgb dut%0d n=%0d: got de=%b rgb=%h want de=1 rgb=%h",
                                 d, n_cyc, o.de, {o.r, o.g, o.b}, want_rgb[n_cyc-2]);
                    end
                end
            end
        end
        $display("test_first_pixels: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_scan(input int cycles);
        obs_t o, e;
        repeat (cycles) begin
            step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                e = model(d, n_cyc);
                n_checks++;
                if (o !== e) begin
                    n_errors++;
                    if (n_errors < 40)
                        $display("FAIL scan dut%0d n=%0d: got %h want %h", d, n_cyc, o, e);
                end
            end
        end
        $display("test_scan: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_sync_timing(input int cycles);
        obs_t o;
        int   ht, vt;
        int   last_fall [2], last_fs [2], hs_run [2], de_run [2], vs_run [2], de_lines [2];
        bit   hs_prev [2], de_prev [2], vs_prev [2], hs_armed [2], de_armed [2], vs_armed [2];
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            hs_prev[d]  = o.hs;  de_prev[d]  = o.de;  vs_prev[d]  = o.vs;
            hs_armed[d] = 1'b0;  de_armed[d] = 1'b0;  vs_armed[d] = 1'b0;
            hs_run[d]   = 0;     de_run[d]   = 0;     vs_run[d]   = 0;
            last_fall[d] = -1;   last_fs[d]  = -1;    de_lines[d] = -1;
        end
        repeat (cycles) begin
            step();
            for (int d = 0; d < 2; d++) begin
                ht = t_ha[d] + t_hf[d] + t_hs[d] + t_hb[d];
                vt = t_va[d] + t_vf[d] + t_vs[d] + t_vb[d];
                o  = observe(d);
                if (hs_prev[d] && !o.hs) begin
                    if (last_fall[d] >= 0) begin
                        n_checks++;
                        if (n_cyc - last_fall[d] != ht) begin
                            n_errors++;
                            $display("FAIL hsync_period dut%0d: got %0d want %0d", d, n_cyc - last_fall[d], ht);
                        end
                    end
                    last_fall[d] = n_cyc;
                    hs_armed[d]  = 1'b1;
                    hs_run[d]    = 0;
                end
                if (!o.hs) hs_run[d]++;
                if (!hs_prev[d] && o.hs && hs_armed[d]) begin
                    n_checks++;
                    if (hs_run[d] != t_hs[d]) begin
                        n_errors++;
                        $display("FAIL hsync_width dut%0d: got %0d want %0d", d, hs_run[d], t_hs[d]);
                    end
                end
                if (vs_prev[d] && !o.vs) begin
                    vs_armed[d] = 1'b1;
                    vs_run[d]   = 0;
                end
                if (!o.vs) vs_run[d]++;
                if (!vs_prev[d] && o.vs && vs_armed[d]) begin
                    n_checks++;
                    if (vs_run[d] != t_vs[d] * ht) begin
                        n_errors++;
                        $display("FAIL vsync_width dut%0d: got %0d want %0d", d, vs_run[d], t_vs[d] * ht);
                    end
                end
                if (o.fs) begin
                    if (last_fs[d] >= 0) begin
                        n_checks++;
                        if (n_cyc - last_fs[d] != ht * vt) begin
                            n_errors++;
                            $display("FAIL frame_period dut%0d: got %0d want %0d", d, n_cyc - last_fs[d], ht * vt);
                        end
                    end
                    if (de_lines[d] >= 0) begin
                        n_checks++;
                        if (de_lines[d] != t_va[d]) begin
                            n_errors++;
                            $display("FAIL de_lines dut%0d: got %0d want %0d", d, de_lines[d], t_va[d]);
                        end
                    end
                    last_fs[d]  = n_cyc;
                    de_lines[d] = 0;
                end
                if (!de_prev[d] && o.de) begin
                    de_armed[d] = 1'b1;
                    de_run[d]   = 0;
                    if (de_lines[d] >= 0) de_lines[d]++;
                end
                if (o.de) de_run[d]++;
                if (de_prev[d] && !o.de && de_armed[d]) begin
                    n_checks++;
                    if (de_run[d] != t_ha[d]) begin
                        n_errors++;
                        $display("FAIL de_width dut%0d: got %0d want %0d", d, de_run[d], t_ha[d]);
                    end
                end
                hs_prev[d] = o.hs;
                de_prev[d] = o.de;
                vs_prev[d] = o.vs;
            end
        end
        $display("test_sync_timing: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_addr_sweep();
        int frame, last, a, prev, maxa, nseen;
        bit seen [96];
        frame = 25 * 11;
        last  = 16 * 6 - 1;
        en = 1'b0;
        step();
        en    = 1'b1;
        n_cyc = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        prev = 0;
        maxa = 0;
        for (int i = 0; i <= frame; i++) begin
            if (i > 0) step();
            a = int'(fb_addr_b);
            if (n_cyc == frame) begin
                n_checks++;
                if (a != 0) begin
                    n_errors++;
                    $display("FAIL addr_second_frame: got %0d want 0", a);
                end
            end else begin
                n_checks++;
                if (a > last || a < 0) begin
                    n_errors++;
                    $display("FAIL addr_bound n=%0d: got %0d want <=%0d", n_cyc, a, last);
                end else begin
                    seen[a] = 1'b1;
                end
                if (n_cyc > 0) begin
                    n_checks++;
                    if (a - prev != 0 && a - prev != 1) begin
                        n_errors++;
                        $display("FAIL addr_step n=%0d: got %0d->%0d want +0/+1", n_cyc, prev, a);
                    end
                end
                if (a > maxa) maxa = a;
                prev = a;
            end
        end
        nseen = 0;
        foreach (seen[i]) if (seen[i]) nseen++;
        n_checks++;
        if (maxa != last || nseen != last + 1) begin
            n_errors++;
            $display("FAIL addr_coverage: got max=%0d seen=%0d want max=%0d seen=%0d", maxa, nseen, last, last + 1);
        end
        $display("test_addr_sweep: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        en = 1'b0;
        step();
        en    = 1'b1;
        n_cyc = 0;
        repeat (300) step();
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            e = model(d, n_cyc);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL pre_reset dut%0d: got %h want %h", d, o, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            n_checks++;
            if (o !== RST_EXP) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got %h want %h", d, o, RST_EXP);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                e = model(d, n_cyc);
                n_checks++;
                if (o.fs !== (n_cyc == 2) || o !== e) begin
                    n_errors++;
                    $display("FAIL post_reset dut%0d n=%0d: got %h want %h", d, n_cyc, o, e);
                end
            end
        end
        $display("test_async_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_en_drop();
        obs_t o, e;
        repeat (100) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                n_checks++;
                if (o !== RST_EXP) begin
                    n_errors++;
                    $display("FAIL en_low dut%0d cyc%0d: got %h want %h", d, i, o, RST_EXP);
                end
            end
        end
        en    = 1'b1;
        n_cyc = 0;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) step();
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                e = model(d, n_cyc);
                n_checks++;
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL en_restart dut%0d n=%0d: got %h want %h", d, n_cyc, o, e);
                end
            end
        end
        $display("test_en_drop: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF800;
        mem[1] = 16'h8410;
        mem[2] = 16'h07E0;
        mem[3] = 16'h001F;
        test_reset();
        test_first_pixels();
        test_scan(1700);
        test_sync_timing(3600);
        test_addr_sweep();
        test_async_reset();
        test_en_drop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
